// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one byte-wide main-memory port between two line requesters.
//   Port 0 is the data cache controller and port 1 is the instruction fill / DMA.
//   Each request moves one cache line of BLOCKSIZE byte beats, either as a fill or as a writeback.
//   Ties are broken round-robin.
//
// Ports
//   clock, reset             rising-edge clock; asynchronous active-low reset
//   req*/we*/addr*/wdata*    per-port line request, direction, line address, writeback line
//   rdata*                   filled line; loaded in the ack cycle, held until the next fill
//   ack*/err*                one-cycle completion / timeout-abort pulses
//   busy                     high from the grant cycle through the ack/err cycle
//   addr_mem, read_mem_enable, write_mem_enable, wdata_mem
//                            beat request to main memory
//   rdata_mem, ready_memory  beat response; a beat completes when ready_memory is high
module mem_port_arbiter #(
   parameter int AWIDTH    = 16,
   parameter int DATAWIDTH = 8,
   parameter int BLOCKSIZE = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           req0,
   input  logic                           req1,
   input  logic                           we0,
   input  logic                           we1,
   input  logic [AWIDTH-1:0]              addr0,
   input  logic [AWIDTH-1:0]              addr1,
   input  logic [DATAWIDTH*BLOCKSIZE-1:0] wdata0,
   input  logic [DATAWIDTH*BLOCKSIZE-1:0] wdata1,
   output logic [DATAWIDTH*BLOCKSIZE-1:0] rdata0,
   output logic [DATAWIDTH*BLOCKSIZE-1:0] rdata1,
   output logic                           ack0,
   output logic                           ack1,
   output logic                           err0,
   output logic                           err1,
   output logic                           busy,
   output logic [AWIDTH-1:0]              addr_mem,
   output logic                           read_mem_enable,
   output logic                           write_mem_enable,
   output logic [DATAWIDTH-1:0]           wdata_mem,
   input  logic [DATAWIDTH-1:0]           rdata_mem,
   input  logic                           ready_memory
);

   localparam int LW = DATAWIDTH * BLOCKSIZE;
   localparam int BW = (BLOCKSIZE > 1) ? $clog2(BLOCKSIZE) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BEAT  = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
   localparam logic [1:0] ABORT = 2'd3;

   logic [1:0]        state_q;
   logic              port_q;
   logic              rr_q;        // port that wins the next tie
   logic              holdoff_q;   // first IDLE cycle after DONE/ABORT ignores req
   logic [BW-1:0]     beat_q;
   logic [TW-1:0]     wait_q;

   logic [AWIDTH-1:0] base_q;
   logic              we_q;
   logic [LW-1:0]     wdata_q;
   logic [LW-1:0]     line_q;
   logic [LW-1:0]     line_nxt;

   logic              in_beat;
   logic              grant_any;
   logic              grant_port;
   logic              last_beat;
   logic              unused_addr_lsbs;

   // Line offset bits are dropped when forming the aligned base.
   assign unused_addr_lsbs = ^{addr0[BW-1:0], addr1[BW-1:0]};

   assign in_beat    = (state_q == BEAT);
   // Gated by reset so busy is 0 while reset is held, even with a request pending.
   assign grant_any  = reset && (state_q == IDLE) && !holdoff_q && (req0 || req1);
   assign grant_port = (req0 && req1) ? rr_q : req1;
   assign last_beat  = (beat_q == BW'(BLOCKSIZE - 1));

   // Current line with this beat's read byte merged in, so the final beat can
   // load the port's rdata directly on its completing edge.
   always_comb begin
      line_nxt = line_q;
      line_nxt[beat_q*DATAWIDTH +: DATAWIDTH] = rdata_mem;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         port_q    <= 1'b0;
         rr_q      <= 1'b0;
         holdoff_q <= 1'b0;
         beat_q    <= '0;
         wait_q    <= '0;
         rdata0    <= '0;
         rdata1    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (holdoff_q) begin
                  holdoff_q <= 1'b0;
               end else if (grant_any) begin
                  port_q  <= grant_port;
                  rr_q    <= ~grant_port;
                  beat_q  <= '0;
                  wait_q  <= '0;
                  state_q <= BEAT;
               end
            end
            BEAT: begin
               if (ready_memory) begin
                  wait_q <= '0;
                  if (last_beat) begin
                     state_q <= DONE;
                     if (!we_q) begin
                        if (port_q) rdata1 <= line_nxt;
                        else        rdata0 <= line_nxt;
                     end
                  end else begin
                     beat_q <= beat_q + BW'(1);
                  end
               end else if (wait_q == TW'(TIMEOUT - 1)) begin
                  // TIMEOUT-th consecutive stalled cycle; the partial line is dropped.
                  state_q <= ABORT;
               end else begin
                  wait_q <= wait_q + TW'(1);
               end
            end
            DONE, ABORT: begin
               state_q   <= IDLE;
               holdoff_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (grant_any) begin
         if (grant_port) begin
            base_q  <= {addr1[AWIDTH-1:BW], {BW{1'b0}}};
            we_q    <= we1;
            wdata_q <= wdata1;
         end else begin
            base_q  <= {addr0[AWIDTH-1:BW], {BW{1'b0}}};
            we_q    <= we0;
            wdata_q <= wdata0;
         end
      end
      if (in_beat && ready_memory && !we_q) begin
         line_q <= line_nxt;
      end
   end

   // Base is line-aligned, so base + beat never carries out of the line.
   assign addr_mem         = in_beat ? (base_q + AWIDTH'(beat_q)) : '0;
   assign read_mem_enable  = in_beat && !we_q;
   assign write_mem_enable = in_beat && we_q;
   assign wdata_mem        = (in_beat && we_q) ? wdata_q[beat_q*DATAWIDTH +: DATAWIDTH] : '0;

   assign ack0 = (state_q == DONE)  && !port_q;
   assign ack1 = (state_q == DONE)  &&  port_q;
   assign err0 = (state_q == ABORT) && !port_q;
   assign err1 = (state_q == ABORT) &&  port_q;
   assign busy = (state_q != IDLE) || grant_any;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Expected beats and completions are
//   queued when a request is issued and popped as the arbiter produces them.
//   Memory read data is a fixed function of the beat address.
module tb_mem_port_arbiter;

   localparam int AW = 16;
   localparam int DW = 8;
   localparam int BS = 4;
   localparam int TO = 255;
   localparam int LW = DW * BS;

   logic          clock = 1'b0;
   logic          reset;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [LW-1:0] wdata0, wdata1;
   logic [LW-1:0] rdata0, rdata1;
   logic          ack0, ack1, err0, err1, busy;
   logic [AW-1:0] addr_mem;
   logic          read_mem_enable, write_mem_enable;
   logic [DW-1:0] wdata_mem;
   logic [DW-1:0] rdata_mem;
   logic          ready_memory;

   always #5 clock = ~clock;

   mem_port_arbiter #(
      .AWIDTH(AW), .DATAWIDTH(DW), .BLOCKSIZE(BS), .TIMEOUT(TO)
   ) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .rdata0(rdata0), .rdata1(rdata1),
      .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .busy(busy),
      .addr_mem(addr_mem), .read_mem_enable(read_mem_enable),
      .write_mem_enable(write_mem_enable), .wdata_mem(wdata_mem),
      .rdata_mem(rdata_mem), .ready_memory(ready_memory)
   );

   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   assign rdata_mem = mem_byte(addr_mem);

   typedef struct packed { logic [15:0] addr; logic we; logic [7:0] wd; } beat_t;
   typedef struct packed { logic port; logic is_err; logic [31:0] line; } cpl_t;

   beat_t       bq[$];
   cpl_t        cq[$];
   logic [31:0] sh_rd [2];
   logic        drop0, drop1;
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  t2_wd  [6];
   logic        t2_rdy [6];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic expect_xfer(input logic port, input logic we, input logic [15:0] addr,
                              input logic [31:0] wd, input int nbeats,
                              input logic is_err, input logic has_cpl);
      logic [15:0] base;
      logic [31:0] line;
      beat_t       b;
      cpl_t        c;
      base = {addr[15:2], 2'b00};
      line = '0;
      for (int k = 0; k < nbeats; k++) begin
         b.addr = base + 16'(k);
         b.we   = we;
         b.wd   = wd[8*k +: 8];
         bq.push_back(b);
         line[8*k +: 8] = mem_byte(b.addr);
      end
      if (has_cpl) begin
         if (!we && !is_err) sh_rd[port] = line;
         c.port   = port;
         c.is_err = is_err;
         c.line   = sh_rd[port];
         cq.push_back(c);
      end
   endtask

   task automatic mon();
      beat_t b;
      cpl_t  c;
      if (reset) begin
         if ((read_mem_enable || write_mem_enable) && ready_memory) begin
            chk("beat_expected", 64'(bq.size() != 0), 1);
            if (bq.size() != 0) begin
               b = bq.pop_front();
               chk("beat_addr", addr_mem, b.addr);
               chk("beat_we", write_mem_enable, b.we);
               if (b.we) chk("beat_wdata", wdata_mem, b.wd);
            end
         end
         if (ack0 || ack1 || err0 || err1) begin
            chk("cpl_expected", 64'(cq.size() != 0), 1);
            if (cq.size() != 0) begin
               c = cq.pop_front();
               chk("cpl_port", {ack1 | err1, ack0 | err0}, c.port ? 2'b10 : 2'b01);
               chk("cpl_kind", err0 | err1, c.is_err);
               chk("cpl_rdata", c.port ? rdata1 : rdata0, c.line);
            end
            drop0 = ack0 | err0;
            drop1 = ack1 | err1;
         end
      end
   endtask

   // One clock: check at the falling edge, then return 1 time unit after the
   // rising edge, releasing any request that was acknowledged.
   task automatic step();
      drop0 = 1'b0;
      drop1 = 1'b0;
      @(negedge clock);
      mon();
      @(posedge clock);
      #1;
      if (drop0) req0 = 1'b0;
      if (drop1) req1 = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (cq.size() != 0 && n < budget) begin
         step();
         n++;
      end
      chk("drain_done", 64'(cq.size()), 0);
   endtask

   initial begin
      reset = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; ready_memory = 1'b1;
      sh_rd[0] = '0; sh_rd[1] = '0;
      t2_wd  = '{8'hDD, 8'hCC, 8'hCC, 8'hCC, 8'hBB, 8'hAA};
      t2_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

      // Reset state, with a request held during reset.
      req0 = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_en", {read_mem_enable, write_mem_enable}, 2'b00);
      chk("rst_addr", addr_mem, 0);
      chk("rst_wdata", wdata_mem, 0);
      chk("rst_pulses", {ack0, ack1, err0, err1}, 4'b0000);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
      req0 = 1'b0;
      reset = 1'b1;
      step();
      chk("idle_busy", busy, 0);

      // T3: simultaneous requests, twice; port 0 then port 1 each round.
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0100;
      req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0208; wdata1 = 32'h11223344;
      expect_xfer(1'b0, 1'b0, 16'h0100, 32'h0, 4, 1'b0, 1'b1);
      expect_xfer(1'b1, 1'b1, 16'h0208, 32'h11223344, 4, 1'b0, 1'b1);
      drain(40);
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0110;
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0214;
      expect_xfer(1'b0, 1'b0, 16'h0110, 32'h0, 4, 1'b0, 1'b1);
      expect_xfer(1'b1, 1'b0, 16'h0214, 32'h0, 4, 1'b0, 1'b1);
      drain(40);

      // T1: fill with ideal memory, exact beat and ack timing.
      step();
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h1237;
      expect_xfer(1'b0, 1'b0, 16'h1237, 32'h0, 4, 1'b0, 1'b1);
      #1;
      chk("t1_busy_grant", busy, 1);
      step();
      for (int k = 0; k < 4; k++) begin
         chk("t1_addr", addr_mem, 16'h1234 + 16'(k));
         chk("t1_ren", read_mem_enable, 1);
         step();
      end
      chk("t1_ack", ack0, 1);
      chk("t1_rdata", rdata0, {mem_byte(16'h1237), mem_byte(16'h1236),
                               mem_byte(16'h1235), mem_byte(16'h1234)});
      chk("t1_en_off", {read_mem_enable, addr_mem}, 0);
      step();
      chk("t1_ack_once", ack0, 0);
      chk("t1_busy_off", busy, 0);

      // T2: writeback with a two-cycle stall on beat 1.
      step();
      req1 = 1'b1; we1 = 1'b1; addr1 = 16'h2001; wdata1 = 32'hAABBCCDD;
      expect_xfer(1'b1, 1'b1, 16'h2001, 32'hAABBCCDD, 4, 1'b0, 1'b1);
      step();
      for (int i = 0; i < 6; i++) begin
         chk("t2_wen", write_mem_enable, 1);
         chk("t2_wdata", wdata_mem, t2_wd[i]);
         ready_memory = t2_rdy[i];
         step();
      end
      ready_memory = 1'b1;
      chk("t2_ack", ack1, 1);
      chk("t2_wen_off", write_mem_enable, 0);
      step();
      chk("t2_ack_once", ack1, 0);

      // T4: timeout on beat 2 of a fill.
      step();
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0041;
      expect_xfer(1'b0, 1'b0, 16'h0041, 32'h0, 2, 1'b1, 1'b1);
      repeat (3) step();
      ready_memory = 1'b0;
      chk("t4_addr", addr_mem, 16'h0042);
      repeat (TO - 1) step();
      chk("t4_waiting", read_mem_enable, 1);
      step();
      chk("t4_err", err0, 1);
      chk("t4_no_ack", ack0, 0);
      chk("t4_en_off", {read_mem_enable, write_mem_enable}, 2'b00);
      chk("t4_rdata_kept", rdata0, {mem_byte(16'h1237), mem_byte(16'h1236),
                                    mem_byte(16'h1235), mem_byte(16'h1234)});
      ready_memory = 1'b1;
      step();
      chk("t4_err_once", err0, 0);

      // T5: reset during beat 2 of a fill, with port 1 pending.
      step();
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h3000;
      expect_xfer(1'b0, 1'b0, 16'h3000, 32'h0, 2, 1'b0, 1'b0);
      step();
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'h3105;
      step();
      step();
      chk("t5_beat2", addr_mem, 16'h3002);
      #1 reset = 1'b0;
      #1;
      chk("t5_rst_en", {read_mem_enable, write_mem_enable}, 2'b00);
      chk("t5_rst_addr", addr_mem, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_pulses", {ack0, ack1, err0, err1}, 4'b0000);
      chk("t5_rst_rdata", {rdata0, rdata1}, 0);
      req0 = 1'b0;
      sh_rd[0] = '0; sh_rd[1] = '0;
      step();
      reset = 1'b1;
      expect_xfer(1'b1, 1'b0, 16'h3105, 32'h0, 4, 1'b0, 1'b1);
      drain(20);

      // T6: port 1 arrives during a port 0 transfer.
      step();
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h4000;
      expect_xfer(1'b0, 1'b0, 16'h4000, 32'h0, 4, 1'b0, 1'b1);
      step();
      step();
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'h5008;
      expect_xfer(1'b1, 1'b0, 16'h5008, 32'h0, 4, 1'b0, 1'b1);
      step();
      step();
      step();
      chk("t6_ack0", {ack0, busy}, 2'b11);
      step();
      chk("t6_gap", {busy, ack0, read_mem_enable}, 3'b000);
      step();
      chk("t6_grant", {busy, read_mem_enable}, 2'b10);
      step();
      chk("t6_beat0", {read_mem_enable, addr_mem}, {1'b1, 16'h5008});
      drain(20);
      chk("beats_left", 64'(bq.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
